// File: rtl/wlevel_monitor.sv
// wlevel_monitor
// Write-domain companion to the async FIFO write-pointer/full logic.
// Synchronizes the read-domain Gray read pointer into the write clock domain,
// converts both Gray pointers to binary and registers a conservative fill
// level, a hysteretic almost-full flag and a sticky overflow error.
//
// Ports
//   i_clk            write-domain clock
//   i_rst_n          asynchronous active-low reset
//   i_readPtrAsync   Gray read pointer from the read domain (asynchronous)
//   i_writePtr       Gray write pointer (next-state value)
//   i_inc            write attempt this cycle
//   i_full           registered full flag
//   i_clearOverflow  clears o_overflow
//   o_readPtr        synchronized Gray read pointer
//   o_level          registered fill level, 0..2**ADDR_W
//   o_almostFull     hysteretic almost-full flag
//   o_overflow       sticky flag: write attempted while full
module wlevel_monitor #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_SET      = 12,
    parameter int unsigned AF_CLR      = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W:0]   i_readPtrAsync,
    input  logic [ADDR_W:0]   i_writePtr,
    input  logic              i_inc,
    input  logic              i_full,
    input  logic              i_clearOverflow,
    output logic [ADDR_W:0]   o_readPtr,
    output logic [ADDR_W:0]   o_level,
    output logic              o_almostFull,
    output logic              o_overflow
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("wlevel_monitor: SYNC_STAGES must be >= 2");
    end
    if (!((AF_CLR < AF_SET) && (AF_SET <= (32'd1 << ADDR_W)))) begin : g_bad_af
        $error("wlevel_monitor: require AF_CLR < AF_SET <= 2**ADDR_W");
    end

    localparam logic [ADDR_W:0] LEVEL_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AF_SET_L  = (ADDR_W+1)'(AF_SET);
    localparam logic [ADDR_W:0] AF_CLR_L  = (ADDR_W+1)'(AF_CLR);

    typedef enum logic {AF_LOW, AF_HIGH} af_state_e;

    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] level_q, level_d;
    logic [ADDR_W:0] rbin, wbin, diff;
    logic            overflow_q, overflow_d;
    af_state_e       state_q, state_d;

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b         = '0;
        b[ADDR_W] = g[ADDR_W];
        for (int unsigned j = 0; j < ADDR_W; j++) begin
            b[ADDR_W-1-j] = b[ADDR_W-j] ^ g[ADDR_W-1-j];
        end
        return b;
    endfunction

    // Plain flop chain, no logic between stages.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= i_readPtrAsync;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign o_readPtr = sync_q[SYNC_STAGES-1];

    // Modular subtraction handles pointer wrap; a result above 2**ADDR_W can
    // only come from illegal pointer combinations and is clamped.
    always_comb begin
        rbin    = gray2bin(o_readPtr);
        wbin    = gray2bin(i_writePtr);
        diff    = wbin - rbin;
        level_d = (diff > LEVEL_MAX) ? LEVEL_MAX : diff;
    end

    always_comb begin
        overflow_d = (i_inc && i_full) || (overflow_q && !i_clearOverflow);
    end

    // Almost-full FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= AF_LOW;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Almost-full FSM: next state, evaluated on level_d so the flag lines up
    // with the registered level.
    always_comb begin
        state_d = state_q;
        case (state_q)
            AF_LOW:  if (level_d >= AF_SET_L) state_d = AF_HIGH;
            AF_HIGH: if (level_d <= AF_CLR_L) state_d = AF_LOW;
            default: state_d = AF_LOW;
        endcase
    end

    // Almost-full FSM: outputs
    always_comb begin
        o_almostFull = (state_q == AF_HIGH);
        o_level      = level_q;
        o_overflow   = overflow_q;
    end

endmodule
